// File: rtl/clock_pkg.sv
// Shared types and constants for the clock display binary-to-BCD path.
package clock_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
    localparam bcd_digit_t BCD_ADJ        = 4'd3;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } b2b_state_e;

endpackage

// File: rtl/bcd_dabble_cell.sv
// One digit of the double-dabble correction: digits of 5 or more get 3 added
// so that the following left shift carries correctly into the next decade.
module bcd_dabble_cell
    import clock_pkg::*;
(
    input  bcd_digit_t i_digit,
    output bcd_digit_t o_digit
);

    assign o_digit = (i_digit >= BCD_ADJ_THRESH) ? i_digit + BCD_ADJ : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with start/done handshake, sticky overflow and leading-zero blanking mask.
module bin2bcd_seq
    import clock_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      number,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int REG_W = WIDTH + BCD_W;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WIDTH - 1);
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    b2b_state_e         r_state;
    b2b_state_e         w_nextState;
    logic [REG_W-1:0]   r_shift;
    logic [CNT_W-1:0]   r_count;
    logic               r_ovfSticky;
    logic               r_busy;
    logic               r_done;
    logic [BCD_W-1:0]   r_bcd;
    logic [DIGITS-1:0]  r_blank;
    logic               r_overflow;

    logic [BCD_W-1:0]   w_adjDigits;
    logic [REG_W-1:0]   w_shifted;
    logic               w_ovfStep;
    logic               w_accept;
    logic               w_load;
    logic               w_busyNext;
    logic [DIGITS-1:0]  w_blankNext;

    // Every digit is corrected from the pre-cycle register value in parallel.
    for (genvar g = 0; g < DIGITS; g++) begin : g_cell
        bcd_dabble_cell u_cell (
            .i_digit (r_shift[WIDTH + 4*g +: 4]),
            .o_digit (w_adjDigits[4*g +: 4])
        );
    end

    assign w_shifted = {w_adjDigits[BCD_W-2:0], r_shift[WIDTH-1:0], 1'b0};
    assign w_ovfStep = w_adjDigits[BCD_W-1] | (w_adjDigits[BCD_W-1 -: 4] > 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = SHIFT;
            SHIFT:   if (r_count == LAST_CNT) w_nextState = DONE;
            DONE:    w_nextState = start ? SHIFT : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Blank bit k is set while digit k and every digit above it are zero.
    always_comb begin
        logic upperZero;
        w_accept    = start && ((r_state == IDLE) || (r_state == DONE));
        w_load      = (r_state == DONE);
        w_busyNext  = (w_nextState != IDLE);
        w_blankNext = '0;
        upperZero   = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            upperZero      = upperZero && (r_shift[WIDTH + 4*k +: 4] == 4'd0);
            w_blankNext[k] = upperZero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_count     <= '0;
            r_ovfSticky <= 1'b0;
        end else if (w_accept) begin
            r_shift     <= {{BCD_W{1'b0}}, number};
            r_count     <= '0;
            r_ovfSticky <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_shift     <= w_shifted;
            r_count     <= r_count + CNT_W'(1);
            r_ovfSticky <= r_ovfSticky | w_ovfStep;
        end
    end

    // Results are copied out of the DONE cycle, before a back-to-back reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bcd      <= '0;
            r_blank    <= BLANK_RST;
            r_overflow <= 1'b0;
        end else begin
            r_busy <= w_busyNext;
            r_done <= w_load;
            if (w_load) begin
                r_bcd      <= r_shift[REG_W-1 -: BCD_W];
                r_blank    <= w_blankNext;
                r_overflow <= r_ovfSticky;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign blank    = r_blank;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: three configurations checked against an
// arithmetic decimal model, with latency, back-to-back and abort scenarios.
module tb_bin2bcd_seq;

    typedef struct {
        logic [39:0] bcd;
        logic [9:0]  blank;
        logic        ovf;
        int          dueCycle;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    logic        startA = 1'b0, startB = 1'b0, startC = 1'b0;
    logic [7:0]  numA = '0, numB = '0;
    logic [15:0] numC = '0;
    logic        busyA, busyB, busyC, doneA, doneB, doneC;
    logic        ovfA, ovfB, ovfC;
    logic [11:0] bcdA;
    logic [7:0]  bcdB;
    logic [19:0] bcdC;
    logic [2:0]  blankA;
    logic [1:0]  blankB;
    logic [4:0]  blankC;

    exp_t qA[$], qB[$], qC[$];
    exp_t eA, eB, eC;

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dutA (
        .clk(clk), .rst_n(rst_n), .start(startA), .number(numA), .busy(busyA),
        .done(doneA), .bcd(bcdA), .blank(blankA), .overflow(ovfA)
    );

    bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dutB (
        .clk(clk), .rst_n(rst_n), .start(startB), .number(numB), .busy(busyB),
        .done(doneB), .bcd(bcdB), .blank(blankB), .overflow(ovfB)
    );

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dutC (
        .clk(clk), .rst_n(rst_n), .start(startC), .number(numC), .busy(busyC),
        .done(doneC), .bcd(bcdC), .blank(blankC), .overflow(ovfC)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Decimal reference: value modulo 10^digits, digit by digit.
    function automatic exp_t model(input longint unsigned value, input int digits, input int due);
        exp_t e;
        longint unsigned lim = 1;
        longint unsigned m;
        longint unsigned tmp;
        longint unsigned p = 1;
        for (int k = 0; k < digits; k++) lim = lim * 10;
        e.ovf   = (value >= lim);
        m       = value % lim;
        tmp     = m;
        e.bcd   = '0;
        e.blank = '0;
        for (int k = 0; k < digits; k++) begin
            e.bcd[4*k +: 4] = 4'(tmp % 10);
            tmp = tmp / 10;
            if (k >= 1 && m < p) e.blank[k] = 1'b1;
            p = p * 10;
        end
        e.dueCycle = due;
        return e;
    endfunction

    task automatic checkValue(input string name, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic checkOutput(input string name, input exp_t e, input logic [39:0] gotBcd,
                               input logic [9:0] gotBlank, input logic gotOvf);
        checkValue({name, " bcd"}, gotBcd, e.bcd);
        checkValue({name, " blank"}, 40'(gotBlank), 40'(e.blank));
        checkValue({name, " overflow"}, 40'(gotOvf), 40'(e.ovf));
        checkValue({name, " done cycle"}, 40'(cyc), 40'(e.dueCycle));
    endtask

    task automatic reportUnexpected(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s unexpected done: got done=1 expected no pending result", name);
    endtask

    task automatic reportMissed(input string name, input int due);
        checks++;
        errors++;
        $display("[TB] FAIL %s missed done: got none by cycle %0d expected at %0d", name, cyc, due);
    endtask

    // Monitor: pops the oldest expectation whenever a unit pulses done.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (doneA) begin
                    if (qA.size() == 0) reportUnexpected("A");
                    else begin eA = qA.pop_front(); checkOutput("A", eA, {28'b0, bcdA}, {7'b0, blankA}, ovfA); end
                end else if (qA.size() > 0 && qA[0].dueCycle < cyc) begin
                    reportMissed("A", qA[0].dueCycle);
                    void'(qA.pop_front());
                end
                if (doneB) begin
                    if (qB.size() == 0) reportUnexpected("B");
                    else begin eB = qB.pop_front(); checkOutput("B", eB, {32'b0, bcdB}, {8'b0, blankB}, ovfB); end
                end else if (qB.size() > 0 && qB[0].dueCycle < cyc) begin
                    reportMissed("B", qB[0].dueCycle);
                    void'(qB.pop_front());
                end
                if (doneC) begin
                    if (qC.size() == 0) reportUnexpected("C");
                    else begin eC = qC.pop_front(); checkOutput("C", eC, {20'b0, bcdC}, {5'b0, blankC}, ovfC); end
                end else if (qC.size() > 0 && qC[0].dueCycle < cyc) begin
                    reportMissed("C", qC[0].dueCycle);
                    void'(qC.pop_front());
                end
            end
        end
    end

    function automatic int qsize(input int unit);
        case (unit)
            0:       return qA.size();
            1:       return qB.size();
            default: return qC.size();
        endcase
    endfunction

    // One-cycle start pulse; the accepting edge is the next rising edge.
    task automatic applyStimulus(input int unit, input logic [15:0] value);
        @(negedge clk);
        case (unit)
            0: begin numA = value[7:0]; startA = 1'b1; qA.push_back(model(value[7:0], 3, cyc + 1 + 9)); end
            1: begin numB = value[7:0]; startB = 1'b1; qB.push_back(model(value[7:0], 2, cyc + 1 + 9)); end
            default: begin numC = value; startC = 1'b1; qC.push_back(model(value, 5, cyc + 1 + 17)); end
        endcase
        @(negedge clk);
        startA = 1'b0;
        startB = 1'b0;
        startC = 1'b0;
        numA = $urandom_range(0, 255);
        numB = $urandom_range(0, 255);
        numC = 16'($urandom);
    endtask

    task automatic waitDrain(input int unit);
        int n = 0;
        while (qsize(unit) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (qsize(unit) != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unit %0d timeout: got %0d pending results expected 0", unit, qsize(unit));
            case (unit)
                0:       qA.delete();
                1:       qB.delete();
                default: qC.delete();
            endcase
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #10;
        checkValue("reset busy", 40'(busyA), 40'd0);
        checkValue("reset done", 40'(doneA), 40'd0);
        checkValue("reset bcd", 40'(bcdA), 40'd0);
        checkValue("reset blank A", 40'(blankA), 40'b110);
        checkValue("reset blank B", 40'(blankB), 40'b10);
        checkValue("reset blank C", 40'(blankC), 40'b11110);
        checkValue("reset overflow", 40'(ovfA), 40'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(0, 16'd255); waitDrain(0);
        applyStimulus(0, 16'd0);   waitDrain(0);
        applyStimulus(0, 16'd7);   waitDrain(0);
        applyStimulus(1, 16'd200); waitDrain(1);
        applyStimulus(1, 16'd99);  waitDrain(1);
        applyStimulus(1, 16'd100); waitDrain(1);

        // A second start mid-conversion must be ignored.
        applyStimulus(2, 16'd65535);
        repeat (3) @(negedge clk);
        checkValue("C busy mid", 40'(busyC), 40'd1);
        startC = 1'b1;
        numC   = 16'd1234;
        @(negedge clk);
        startC = 1'b0;
        waitDrain(2);
        @(negedge clk);
        checkValue("C busy after", 40'(busyC), 40'd0);

        // Back-to-back: start held through the DONE cycle.
        @(negedge clk);
        numA   = 8'd59;
        startA = 1'b1;
        qA.push_back(model(59, 3, cyc + 1 + 9));
        qA.push_back(model(60, 3, cyc + 1 + 18));
        @(negedge clk);
        numA = 8'd60;
        repeat (9) @(negedge clk);
        startA = 1'b0;
        waitDrain(0);

        for (int i = 0; i < 30; i++) begin
            int unit;
            unit = $urandom_range(0, 2);
            applyStimulus(unit, (unit == 2) ? 16'($urandom) : 16'($urandom_range(0, 255)));
            waitDrain(unit);
        end

        // Abort mid-conversion: outputs return to reset values, no done follows.
        applyStimulus(0, 16'd200);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkValue("abort busy", 40'(busyA), 40'd0);
        checkValue("abort done", 40'(doneA), 40'd0);
        checkValue("abort bcd", 40'(bcdA), 40'd0);
        checkValue("abort blank", 40'(blankA), 40'b110);
        checkValue("abort overflow", 40'(ovfA), 40'd0);
        qA.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        applyStimulus(0, 16'd123); waitDrain(0);

        waitDrain(1);
        waitDrain(2);
        repeat (20) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
